// File: rtl/mux_scan_pkg.sv
// Shared types, constants and sizing helper for the mux scan sequencer.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2
   } scan_state_t;

   localparam int NUM_CH_DEF = 8;
   localparam int SEL_W_DEF  = 3;
   localparam int SETTLE_W   = 4;

   // Smallest select width that can address num_ch channels (num_ch >= 2).
   function automatic int sel_width(input int num_ch);
      int w;
      w = 1;
      while ((1 << w) < num_ch) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Valid/ready result stream from the scan sequencer to its consumer.
interface mux_scan_sequencer_if
   import mux_scan_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF
);

   logic [NUM_CH-1:0] data_out;
   logic              data_valid;
   logic              data_ready;

   modport master (
      output data_out,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_out,
      input  data_valid,
      output data_ready
   );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; expire flags the last settle cycle of a channel.
module settle_timer
   import mux_scan_pkg::*;
#(
   parameter int W = SETTLE_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         expire
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != {W{1'b0}})) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the mux select over every channel, samples each after a settle delay
// and publishes the assembled word on a valid/ready stream.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int NUM_CH        = NUM_CH_DEF,
   parameter int SEL_W         = sel_width(NUM_CH),
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [SEL_W-1:0]      sel,
   input  logic                  mux_in,
   output logic                  busy,
   output logic [CNT_W-1:0]      scan_count,
   mux_scan_sequencer_if.master  dout
);

   localparam logic [SEL_W-1:0]    LAST_SEL    = SEL_W'(NUM_CH - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_VAL  = SETTLE_W'(SETTLE_CYCLES);
   localparam scan_state_t         FIRST_STATE = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;

   scan_state_t        state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               busy_q, busy_d;
   logic [NUM_CH-1:0]  capture_q, capture_d;
   logic [NUM_CH-1:0]  data_q, data_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               tmr_load;
   logic               tmr_dec;
   logic               tmr_expire;

   // With zero settle cycles the FSM never enters SETTLE, so expire is ignored.
   settle_timer #(.W(SETTLE_W)) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (SETTLE_VAL),
      .dec      (tmr_dec),
      .expire   (tmr_expire)
   );

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      busy_d    = busy_q;
      capture_d = capture_q;
      data_d    = data_q;
      valid_d   = valid_q;
      count_d   = count_q;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;

      // Transfer clears valid first; a completion can only occur while valid is low.
      if (valid_q && dout.data_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (abort && (state_q != IDLE)) begin
         state_d   = IDLE;
         sel_d     = {SEL_W{1'b0}};
         busy_d    = 1'b0;
         capture_d = {NUM_CH{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort && (!valid_q || dout.data_ready)) begin
                  sel_d     = {SEL_W{1'b0}};
                  capture_d = {NUM_CH{1'b0}};
                  busy_d    = 1'b1;
                  tmr_load  = 1'b1;
                  state_d   = FIRST_STATE;
               end else begin
                  sel_d  = {SEL_W{1'b0}};
                  busy_d = 1'b0;
               end
            end
            SETTLE: begin
               tmr_dec = 1'b1;
               if (tmr_expire) begin
                  state_d = SAMPLE;
               end else begin
                  state_d = SETTLE;
               end
            end
            SAMPLE: begin
               capture_d[sel_q] = mux_in;
               if (sel_q == LAST_SEL) begin
                  data_d  = capture_d;
                  valid_d = 1'b1;
                  count_d = count_q + CNT_W'(1);
                  busy_d  = 1'b0;
                  sel_d   = {SEL_W{1'b0}};
                  state_d = IDLE;
               end else begin
                  sel_d    = sel_q + SEL_W'(1);
                  tmr_load = 1'b1;
                  state_d  = FIRST_STATE;
               end
            end
            default: begin
               state_d = IDLE;
               sel_d   = {SEL_W{1'b0}};
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= {SEL_W{1'b0}};
         busy_q    <= 1'b0;
         capture_q <= {NUM_CH{1'b0}};
         data_q    <= {NUM_CH{1'b0}};
         valid_q   <= 1'b0;
         count_q   <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         capture_q <= capture_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
      end
   end

   assign sel             = sel_q;
   assign busy            = busy_q;
   assign scan_count      = count_q;
   assign dout.data_out   = data_q;
   assign dout.data_valid = valid_q;

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Control stage directly upstream of the 8:1 data-select mux.
- Steps the mux select through channels 0..7, waits a programmable settle time on each, then samples the mux output bit.
- Assembles the eight samples into one byte and hands it downstream over a valid/ready interface.
- Converts the mux's serial, select-driven view of eight inputs back into a parallel word for the rest of the design.

Parameters:
- NUM_CH, 8, number of mux channels scanned per pass; fixed at 8 for this mux, ≥2 legal.
- SEL_W, 3, select width; must equal clog2(NUM_CH).
- SETTLE_CYCLES, 1, idle cycles after a select change before sampling; 0..15 legal.
- CNT_W, 8, width of the completed-scan counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one full scan; single-cycle pulse or level.
- abort  in  1  synchronous cancel of an in-progress scan.
- sel  out  SEL_W  mux select; sel[0] drives S0 (LSB), sel[1] drives S1, sel[2] drives S2.
- mux_in  in  1  mux output being sampled.
- busy  out  1  high while a scan is in progress.
- data_out  out  NUM_CH  assembled byte; bit i = sample taken with sel==i.
- data_valid  out  1  data_out holds an unconsumed result.
- data_ready  in  1  downstream accepts data_out.
- scan_count  out  CNT_W  number of completed scans, wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock domain (clk); rst is asynchronous, active-high.
- Reset values (all outputs and internal registers):
  - sel=0, busy=0, data_out=0, data_valid=0, scan_count=0.
  - State IDLE; capture register=0; settle counter=0.
- FSM states: IDLE, SETTLE, SAMPLE. All outputs are registered.
- IDLE:
  - sel held at 0, busy=0.
  - start is accepted when start=1, abort=0, and (data_valid=0 or data_ready=1).
  - On accept: sel<=0, settle counter<=SETTLE_CYCLES, capture<=0, busy<=1.
  - Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE.
  - start that is not accepted is dropped, not queued.
- SETTLE: settle counter decrements each cycle; on the cycle it reaches 1, next state is SAMPLE.
- SAMPLE:
  - capture[sel]<=mux_in.
  - If sel==NUM_CH-1: data_out<=capture with bit NUM_CH-1 set to mux_in; data_valid<=1; scan_count<=scan_count+1; busy<=0; sel<=0; next state IDLE.
  - Otherwise: sel<=sel+1, counter reloaded, next state SETTLE (or SAMPLE if SETTLE_CYCLES=0).
- Latency: each channel takes SETTLE_CYCLES+1 cycles. data_valid rises NUM_CH*(SETTLE_CYCLES+1) clock edges after the accepting edge (16 edges at the defaults; 8 edges with SETTLE_CYCLES=0).
- Output handshake:
  - A transfer occurs on any edge with data_valid=1 and data_ready=1; data_valid clears on that edge.
  - data_out is stable while data_valid=1 and data_ready=0.
  - data_out retains its last value after the transfer.
- Simultaneous transfer and start in IDLE: the transfer completes and the scan starts on the same edge. A new completion cannot coincide with data_valid=1, by construction.
- abort:
  - In SETTLE or SAMPLE: next state IDLE, sel<=0, busy<=0, partial capture discarded.
  - data_out, data_valid and scan_count are unchanged.
  - Takes priority over a same-cycle final SAMPLE, so no result is produced.
  - In IDLE, abort blocks start that cycle.
- Reset mid-scan: everything returns to reset values immediately; any pending data_valid is lost.
- scan_count wraps from 2^CNT_W-1 to 0 without a flag.
- sel never exceeds NUM_CH-1.

Decomposition:
- Shared package mux_scan_pkg:
  - State enum scan_state_t {IDLE, SETTLE, SAMPLE}.
  - Constants NUM_CH_DEF=8 and SEL_W_DEF=3.
  - Function computing SEL_W from NUM_CH.
- One natural sub-module: settle_timer.
  - Loadable down-counter with a load input and an expire output.
  - Instantiated once, and bypassed when SETTLE_CYCLES=0.
- Everything else (FSM, capture register, output register, counter) stays in the top.

Test Plan:
- Reset then one start pulse, SETTLE_CYCLES=1, mux model returning D=8'hA5: sel walks 0..7 holding each value for 2 cycles; data_valid rises 16 edges after the accept; data_out=8'hA5; scan_count=1.
- SETTLE_CYCLES=0, D=8'h3C, data_ready held 0 for 5 cycles after valid: data_out stays 8'h3C while valid; start pulses during the hold are ignored (busy stays 0); clears on the first ready.
- Back-to-back scans, data_ready=1 and start=1 together on the valid cycle: the transfer and the new accept happen on the same edge; the second result 8'h5A is valid 16 edges later; scan_count=2.
- abort asserted with sel==4: busy drops the next edge; sel=0; data_valid stays 0; scan_count unchanged; the following full scan returns the correct byte.
- rst asserted asynchronously mid-SETTLE (between clock edges): all outputs read reset values before the next edge; sel=0, data_valid=0.
- CNT_W=2, run 5 scans: scan_count sequence 1,2,3,0,1.
